// File: rtl/control_sequencer_if.sv
// Control bundle between the hardwired sequencer and the single-bus datapath:
// instruction/handshake inputs to the sequencer and every datapath strobe back.
interface control_sequencer_if;
    logic        start;
    logic        stall;
    logic [31:0] IR;

    logic PCout, Zlowout, MDRout, Cout, BAout, Rout;
    logic MARin, Zin, PCin, MDRin, IRin, Yin, Rin, IncPC;
    logic Gra, Grb, Grc;
    logic Read, Write;
    logic ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT;
    logic run;
    logic halted;

    modport master (
        input  start, stall, IR,
        output PCout, Zlowout, MDRout, Cout, BAout, Rout,
        output MARin, Zin, PCin, MDRin, IRin, Yin, Rin, IncPC,
        output Gra, Grb, Grc,
        output Read, Write,
        output ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT,
        output run, halted
    );

    modport slave (
        output start, stall, IR,
        input  PCout, Zlowout, MDRout, Cout, BAout, Rout,
        input  MARin, Zin, PCin, MDRin, IRin, Yin, Rin, IncPC,
        input  Gra, Grb, Grc,
        input  Read, Write,
        input  ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT,
        input  run, halted
    );
endinterface

// File: rtl/control_sequencer.sv
// Hardwired Moore sequencer: walks IDLE -> T0..T7 -> T0 per instruction, decoding
// the live IR opcode from T3 on; strobes are a pure function of state and IR, gated by stall.
module control_sequencer #(
    parameter int OPC_W = 5
) (
    input  logic                 clk,
    input  logic                 clear,
    control_sequencer_if.master  bus
);

    localparam logic [OPC_W-1:0] OP_LD   = OPC_W'(5'b00000);
    localparam logic [OPC_W-1:0] OP_LDI  = OPC_W'(5'b00001);
    localparam logic [OPC_W-1:0] OP_ST   = OPC_W'(5'b00010);
    localparam logic [OPC_W-1:0] OP_ADD  = OPC_W'(5'b00011);
    localparam logic [OPC_W-1:0] OP_SUB  = OPC_W'(5'b00100);
    localparam logic [OPC_W-1:0] OP_AND  = OPC_W'(5'b00101);
    localparam logic [OPC_W-1:0] OP_OR   = OPC_W'(5'b00110);
    localparam logic [OPC_W-1:0] OP_SHR  = OPC_W'(5'b00111);
    localparam logic [OPC_W-1:0] OP_SHL  = OPC_W'(5'b01000);
    localparam logic [OPC_W-1:0] OP_ROR  = OPC_W'(5'b01001);
    localparam logic [OPC_W-1:0] OP_ROL  = OPC_W'(5'b01010);
    localparam logic [OPC_W-1:0] OP_NEG  = OPC_W'(5'b01110);
    localparam logic [OPC_W-1:0] OP_NOT  = OPC_W'(5'b01111);
    localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(5'b11011);

    typedef enum logic [3:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_HALT
    } state_t;

    typedef enum logic [2:0] {
        C_LD, C_LDI, C_ST, C_ALU2, C_ALU1, C_STOP
    } cls_t;

    // alu bit order: add, sub, and, or, shr, shl, ror, rol, neg, not
    typedef struct packed {
        logic       pc_drv;
        logic       zlow_drv;
        logic       mdr_drv;
        logic       c_drv;
        logic       ba_drv;
        logic       r_drv;
        logic       mar_en;
        logic       z_en;
        logic       pc_en;
        logic       mdr_en;
        logic       ir_en;
        logic       y_en;
        logic       r_en;
        logic       pc_inc;
        logic       gra;
        logic       grb;
        logic       grc;
        logic       mem_rd;
        logic       mem_wr;
        logic [9:0] alu;
    } strobe_t;

    localparam logic [9:0] ALU_ADD = 10'b10_0000_0000;

    state_t           state;
    cls_t             cls;
    state_t           last_t;
    logic [9:0]       alu_op;
    logic [OPC_W-1:0] opcode;
    strobe_t          dec;
    strobe_t          gated;
    logic             ir_unused;

    assign opcode    = bus.IR[31 -: OPC_W];
    assign ir_unused = ^bus.IR[31-OPC_W:0];

    function automatic state_t succ(input state_t s);
        case (s)
            S_T0:    return S_T1;
            S_T1:    return S_T2;
            S_T2:    return S_T3;
            S_T3:    return S_T4;
            S_T4:    return S_T5;
            S_T5:    return S_T6;
            S_T6:    return S_T7;
            default: return S_T0;
        endcase
    endfunction

    always_comb begin
        cls    = C_STOP;
        alu_op = '0;
        case (opcode)
            OP_LD:   cls = C_LD;
            OP_LDI:  cls = C_LDI;
            OP_ST:   cls = C_ST;
            OP_ADD:  begin cls = C_ALU2; alu_op = 10'b10_0000_0000; end
            OP_SUB:  begin cls = C_ALU2; alu_op = 10'b01_0000_0000; end
            OP_AND:  begin cls = C_ALU2; alu_op = 10'b00_1000_0000; end
            OP_OR:   begin cls = C_ALU2; alu_op = 10'b00_0100_0000; end
            OP_SHR:  begin cls = C_ALU2; alu_op = 10'b00_0010_0000; end
            OP_SHL:  begin cls = C_ALU2; alu_op = 10'b00_0001_0000; end
            OP_ROR:  begin cls = C_ALU2; alu_op = 10'b00_0000_1000; end
            OP_ROL:  begin cls = C_ALU2; alu_op = 10'b00_0000_0100; end
            OP_NEG:  begin cls = C_ALU1; alu_op = 10'b00_0000_0010; end
            OP_NOT:  begin cls = C_ALU1; alu_op = 10'b00_0000_0001; end
            OP_HALT: cls = C_STOP;
            default: cls = C_STOP;
        endcase
    end

    // Final T-state of each instruction class; only consulted from T3 onward
    always_comb begin
        case (cls)
            C_LD, C_ST:     last_t = S_T7;
            C_LDI, C_ALU2:  last_t = S_T5;
            C_ALU1:         last_t = S_T4;
            default:        last_t = S_T3;
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (bus.start && !bus.stall) state <= S_T0;
                S_HALT: state <= S_HALT;
                default: begin
                    if (!bus.stall) begin
                        if (state == S_T3 && cls == C_STOP) state <= S_HALT;
                        else if (state == last_t)           state <= S_T0;
                        else                                state <= succ(state);
                    end
                end
            endcase
        end
    end

    always_comb begin
        dec = '0;
        case (state)
            S_T0: begin
                dec.pc_drv = 1'b1; dec.mar_en = 1'b1; dec.pc_inc = 1'b1; dec.z_en = 1'b1;
            end
            S_T1: begin
                dec.zlow_drv = 1'b1; dec.pc_en = 1'b1; dec.mem_rd = 1'b1; dec.mdr_en = 1'b1;
            end
            S_T2: begin
                dec.mdr_drv = 1'b1; dec.ir_en = 1'b1;
            end
            S_T3: begin
                case (cls)
                    C_LD, C_LDI, C_ST: begin
                        dec.grb = 1'b1; dec.ba_drv = 1'b1; dec.y_en = 1'b1;
                    end
                    C_ALU2: begin
                        dec.grb = 1'b1; dec.r_drv = 1'b1; dec.y_en = 1'b1;
                    end
                    C_ALU1: begin
                        dec.grb = 1'b1; dec.r_drv = 1'b1; dec.alu = alu_op; dec.z_en = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T4: begin
                case (cls)
                    C_LD, C_LDI, C_ST: begin
                        dec.c_drv = 1'b1; dec.alu = ALU_ADD; dec.z_en = 1'b1;
                    end
                    C_ALU2: begin
                        dec.grc = 1'b1; dec.r_drv = 1'b1; dec.alu = alu_op; dec.z_en = 1'b1;
                    end
                    C_ALU1: begin
                        dec.zlow_drv = 1'b1; dec.gra = 1'b1; dec.r_en = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T5: begin
                case (cls)
                    C_LD, C_ST: begin
                        dec.zlow_drv = 1'b1; dec.mar_en = 1'b1;
                    end
                    C_LDI, C_ALU2: begin
                        dec.zlow_drv = 1'b1; dec.gra = 1'b1; dec.r_en = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T6: begin
                case (cls)
                    C_LD: begin
                        dec.mem_rd = 1'b1; dec.mdr_en = 1'b1;
                    end
                    C_ST: begin
                        dec.gra = 1'b1; dec.r_drv = 1'b1; dec.mdr_en = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_T7: begin
                case (cls)
                    C_LD: begin
                        dec.mdr_drv = 1'b1; dec.gra = 1'b1; dec.r_en = 1'b1;
                    end
                    C_ST:    dec.mem_wr = 1'b1;
                    default: ;
                endcase
            end
            default: ;
        endcase
    end

    // Stall blanks every strobe in the same cycle; the state register holds meanwhile
    assign gated = bus.stall ? '0 : dec;

    assign bus.PCout   = gated.pc_drv;
    assign bus.Zlowout = gated.zlow_drv;
    assign bus.MDRout  = gated.mdr_drv;
    assign bus.Cout    = gated.c_drv;
    assign bus.BAout   = gated.ba_drv;
    assign bus.Rout    = gated.r_drv;
    assign bus.MARin   = gated.mar_en;
    assign bus.Zin     = gated.z_en;
    assign bus.PCin    = gated.pc_en;
    assign bus.MDRin   = gated.mdr_en;
    assign bus.IRin    = gated.ir_en;
    assign bus.Yin     = gated.y_en;
    assign bus.Rin     = gated.r_en;
    assign bus.IncPC   = gated.pc_inc;
    assign bus.Gra     = gated.gra;
    assign bus.Grb     = gated.grb;
    assign bus.Grc     = gated.grc;
    assign bus.Read    = gated.mem_rd;
    assign bus.Write   = gated.mem_wr;
    assign bus.ADD     = gated.alu[9];
    assign bus.SUB     = gated.alu[8];
    assign bus.AND     = gated.alu[7];
    assign bus.OR      = gated.alu[6];
    assign bus.SHR     = gated.alu[5];
    assign bus.SHL     = gated.alu[4];
    assign bus.ROR     = gated.alu[3];
    assign bus.ROL     = gated.alu[2];
    assign bus.NEG     = gated.alu[1];
    assign bus.NOT     = gated.alu[0];

    assign bus.run    = (state != S_IDLE) && (state != S_HALT);
    assign bus.halted = (state == S_HALT);

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a small single-bus datapath model driven by the DUT strobes,
// a program table with per-cycle strobe expectations fed through a scoreboard queue.
module tb_control_sequencer;

    logic clk = 1'b0;
    logic clear = 1'b0;
    always #5 clk = ~clk;

    control_sequencer_if bus();
    control_sequencer #(.OPC_W(5)) dut (.clk(clk), .clear(clear), .bus(bus));

    localparam logic [28:0] M_PCOUT   = 29'd1 << 28;
    localparam logic [28:0] M_ZLOWOUT = 29'd1 << 27;
    localparam logic [28:0] M_MDROUT  = 29'd1 << 26;
    localparam logic [28:0] M_COUT    = 29'd1 << 25;
    localparam logic [28:0] M_BAOUT   = 29'd1 << 24;
    localparam logic [28:0] M_ROUT    = 29'd1 << 23;
    localparam logic [28:0] M_MARIN   = 29'd1 << 22;
    localparam logic [28:0] M_ZIN     = 29'd1 << 21;
    localparam logic [28:0] M_PCIN    = 29'd1 << 20;
    localparam logic [28:0] M_MDRIN   = 29'd1 << 19;
    localparam logic [28:0] M_IRIN    = 29'd1 << 18;
    localparam logic [28:0] M_YIN     = 29'd1 << 17;
    localparam logic [28:0] M_RIN     = 29'd1 << 16;
    localparam logic [28:0] M_INCPC   = 29'd1 << 15;
    localparam logic [28:0] M_GRA     = 29'd1 << 14;
    localparam logic [28:0] M_GRB     = 29'd1 << 13;
    localparam logic [28:0] M_GRC     = 29'd1 << 12;
    localparam logic [28:0] M_READ    = 29'd1 << 11;
    localparam logic [28:0] M_WRITE   = 29'd1 << 10;
    localparam logic [28:0] M_ADD     = 29'd1 << 9;
    localparam logic [28:0] M_SUB     = 29'd1 << 8;
    localparam logic [28:0] M_AND     = 29'd1 << 7;
    localparam logic [28:0] M_OR      = 29'd1 << 6;
    localparam logic [28:0] M_SHR     = 29'd1 << 5;
    localparam logic [28:0] M_SHL     = 29'd1 << 4;
    localparam logic [28:0] M_ROR     = 29'd1 << 3;
    localparam logic [28:0] M_ROL     = 29'd1 << 2;
    localparam logic [28:0] M_NEG     = 29'd1 << 1;
    localparam logic [28:0] M_NOT     = 29'd1 << 0;

    // Datapath model
    logic [31:0] pc, ir, mar, mdr, y, z;
    logic [31:0] rf  [16]  = '{default: 32'h0};
    logic [31:0] mem [256] = '{default: 32'h0};
    logic [31:0] pc_init;
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;
    logic [3:0]  ra, rb, rc, sel;
    logic [31:0] cval, bus_v, alu_res;
    logic [4:0]  sh;

    assign bus.IR = ir;
    assign ra   = ir[26:23];
    assign rb   = ir[22:19];
    assign rc   = ir[18:15];
    assign cval = {{13{ir[18]}}, ir[18:0]};
    assign sel  = bus.Gra ? ra : (bus.Grb ? rb : (bus.Grc ? rc : 4'd0));
    assign sh   = bus_v[4:0];

    always_comb begin
        bus_v = 32'h0;
        if (bus.PCout)   bus_v = pc;
        if (bus.Zlowout) bus_v = z;
        if (bus.MDRout)  bus_v = mdr;
        if (bus.Cout)    bus_v = cval;
        if (bus.BAout)   bus_v = (sel == 4'd0) ? 32'h0 : rf[sel];
        if (bus.Rout)    bus_v = rf[sel];
    end

    always_comb begin
        alu_res = 32'h0;
        if (bus.IncPC) alu_res = bus_v + 32'd1;
        if (bus.ADD)   alu_res = y + bus_v;
        if (bus.SUB)   alu_res = y - bus_v;
        if (bus.AND)   alu_res = y & bus_v;
        if (bus.OR)    alu_res = y | bus_v;
        if (bus.SHR)   alu_res = y >> sh;
        if (bus.SHL)   alu_res = y << sh;
        if (bus.ROR)   alu_res = (y >> sh) | (y << (6'd32 - {1'b0, sh}));
        if (bus.ROL)   alu_res = (y << sh) | (y >> (6'd32 - {1'b0, sh}));
        if (bus.NEG)   alu_res = 32'h0 - bus_v;
        if (bus.NOT)   alu_res = ~bus_v;
    end

    always @(posedge clk) begin
        if (ld_en) mem[ld_addr] <= ld_data;
        if (!clear) begin
            pc <= pc_init;
        end else begin
            if (bus.PCin)  pc  <= bus_v;
            if (bus.IRin)  ir  <= bus_v;
            if (bus.MARin) mar <= bus_v;
            if (bus.Yin)   y   <= bus_v;
            if (bus.Zin)   z   <= alu_res;
            if (bus.MDRin) mdr <= bus.Read ? mem[mar[7:0]] : bus_v;
            if (bus.Rin)   rf[sel] <= bus_v;
            if (bus.Write) mem[mar[7:0]] <= mdr;
        end
    end

    int total = 0;
    int bad   = 0;
    logic [30:0] sq[$];

    typedef struct {
        string       nm;
        logic [31:0] ir;
        int          lat;
        int          kind;   // 0: register result, 1: memory result, 2: halt
        int          idx;
        logic [31:0] val;
    } vec_t;
    vec_t tv[16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h", nm, act, exp);
        end
    endtask

    function automatic logic [30:0] obs();
        return {bus.run, bus.halted,
                bus.PCout, bus.Zlowout, bus.MDRout, bus.Cout, bus.BAout, bus.Rout,
                bus.MARin, bus.Zin, bus.PCin, bus.MDRin, bus.IRin, bus.Yin, bus.Rin, bus.IncPC,
                bus.Gra, bus.Grb, bus.Grc, bus.Read, bus.Write,
                bus.ADD, bus.SUB, bus.AND, bus.OR, bus.SHR, bus.SHL, bus.ROR, bus.ROL,
                bus.NEG, bus.NOT};
    endfunction

    function automatic logic [28:0] opm(input logic [4:0] opc);
        case (opc)
            5'b00011: return M_ADD;
            5'b00100: return M_SUB;
            5'b00101: return M_AND;
            5'b00110: return M_OR;
            5'b00111: return M_SHR;
            5'b01000: return M_SHL;
            5'b01001: return M_ROR;
            5'b01010: return M_ROL;
            5'b01110: return M_NEG;
            5'b01111: return M_NOT;
            default:  return 29'd0;
        endcase
    endfunction

    function automatic logic [28:0] exp_strb(input logic [4:0] opc, input int k);
        if (k == 0) return M_PCOUT | M_MARIN | M_INCPC | M_ZIN;
        if (k == 1) return M_ZLOWOUT | M_PCIN | M_READ | M_MDRIN;
        if (k == 2) return M_MDROUT | M_IRIN;
        case (opc)
            5'b00000, 5'b00001, 5'b00010: begin
                if (k == 3) return M_GRB | M_BAOUT | M_YIN;
                if (k == 4) return M_COUT | M_ADD | M_ZIN;
                if (k == 5 && opc == 5'b00001) return M_ZLOWOUT | M_GRA | M_RIN;
                if (k == 5) return M_ZLOWOUT | M_MARIN;
                if (k == 6 && opc == 5'b00000) return M_READ | M_MDRIN;
                if (k == 6 && opc == 5'b00010) return M_GRA | M_ROUT | M_MDRIN;
                if (k == 7 && opc == 5'b00000) return M_MDROUT | M_GRA | M_RIN;
                if (k == 7 && opc == 5'b00010) return M_WRITE;
                return 29'd0;
            end
            5'b01110, 5'b01111: begin
                if (k == 3) return M_GRB | M_ROUT | opm(opc) | M_ZIN;
                if (k == 4) return M_ZLOWOUT | M_GRA | M_RIN;
                return 29'd0;
            end
            5'b00011, 5'b00100, 5'b00101, 5'b00110,
            5'b00111, 5'b01000, 5'b01001, 5'b01010: begin
                if (k == 3) return M_GRB | M_ROUT | M_YIN;
                if (k == 4) return M_GRC | M_ROUT | opm(opc) | M_ZIN;
                if (k == 5) return M_ZLOWOUT | M_GRA | M_RIN;
                return 29'd0;
            end
            default: return 29'd0;
        endcase
    endfunction

    function automatic logic [31:0] enc_m(input logic [4:0] o, input logic [3:0] a,
                                          input logic [3:0] b, input logic [18:0] c);
        return {o, a, b, c};
    endfunction

    function automatic logic [31:0] enc_r(input logic [4:0] o, input logic [3:0] a,
                                          input logic [3:0] b, input logic [3:0] c);
        return {o, a, b, c, 15'd0};
    endfunction

    task automatic poke(input logic [7:0] a, input logic [31:0] d);
        ld_addr = a;
        ld_data = d;
        ld_en   = 1'b1;
        @(posedge clk);
        #1 ld_en = 1'b0;
    endtask

    task automatic do_start();
        @(posedge clk);
        #1 bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
    endtask

    task automatic sb_check(input string nm);
        logic [30:0] e;
        @(negedge clk);
        if (sq.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s scoreboard empty act=%h", nm, obs());
        end else begin
            e = sq.pop_front();
            chk(nm, {1'b0, obs()}, {1'b0, e});
        end
    endtask

    initial begin
        bus.start = 1'b0;
        bus.stall = 1'b0;
        ld_en     = 1'b0;
        ld_addr   = 8'h0;
        ld_data   = 32'h0;
        pc_init   = 32'h0;

        tv[0]  = '{"ld",   enc_m(5'b00000, 4'd1,  4'd0, 19'h5A), 8, 0, 1,  32'h0000_0055};
        tv[1]  = '{"st",   enc_m(5'b00010, 4'd1,  4'd0, 19'h5B), 8, 1, 91, 32'h0000_0055};
        tv[2]  = '{"ldi1", enc_m(5'b00001, 4'd1,  4'd0, 19'd5),  6, 0, 1,  32'd5};
        tv[3]  = '{"ldi2", enc_m(5'b00001, 4'd2,  4'd0, 19'd7),  6, 0, 2,  32'd7};
        tv[4]  = '{"ldi9", enc_m(5'b00001, 4'd9,  4'd0, 19'd2),  6, 0, 9,  32'd2};
        tv[5]  = '{"add",  enc_r(5'b00011, 4'd3,  4'd1, 4'd2),   6, 0, 3,  32'd12};
        tv[6]  = '{"neg",  enc_r(5'b01110, 4'd4,  4'd3, 4'd0),   5, 0, 4,  32'hFFFF_FFF4};
        tv[7]  = '{"sub",  enc_r(5'b00100, 4'd5,  4'd3, 4'd1),   6, 0, 5,  32'd7};
        tv[8]  = '{"and",  enc_r(5'b00101, 4'd6,  4'd3, 4'd2),   6, 0, 6,  32'd4};
        tv[9]  = '{"or",   enc_r(5'b00110, 4'd7,  4'd3, 4'd2),   6, 0, 7,  32'd15};
        tv[10] = '{"shr",  enc_r(5'b00111, 4'd8,  4'd3, 4'd9),   6, 0, 8,  32'd3};
        tv[11] = '{"shl",  enc_r(5'b01000, 4'd10, 4'd3, 4'd9),   6, 0, 10, 32'd48};
        tv[12] = '{"ror",  enc_r(5'b01001, 4'd11, 4'd4, 4'd9),   6, 0, 11, 32'h3FFF_FFFD};
        tv[13] = '{"rol",  enc_r(5'b01010, 4'd12, 4'd4, 4'd9),   6, 0, 12, 32'hFFFF_FFD3};
        tv[14] = '{"not",  enc_r(5'b01111, 4'd13, 4'd3, 4'd0),   5, 0, 13, 32'hFFFF_FFF3};
        tv[15] = '{"halt", 32'hD800_0000,                        4, 2, 0,  32'h0};

        // Reset and load program while the sequencer is held idle
        #2 chk("reset_outputs", {1'b0, obs()}, 32'h0);
        for (int i = 0; i < 16; i++) poke(8'(i), tv[i].ir);
        poke(8'h5A, 32'h0000_0055);
        chk("reset_held_outputs", {1'b0, obs()}, 32'h0);
        @(posedge clk);
        #1 clear = 1'b1;
        @(negedge clk);
        chk("idle_after_reset", {1'b0, obs()}, 32'h0);

        // start while stalled must not leave IDLE
        @(posedge clk);
        #1 begin bus.start = 1'b1; bus.stall = 1'b1; end
        @(posedge clk);
        #1 bus.stall = 1'b0;
        chk("start_blocked_by_stall", {1'b0, obs()}, 32'h0);
        @(posedge clk);
        #1 bus.start = 1'b0;

        // Back-to-back program through the table
        for (int i = 0; i < 16; i++) begin
            for (int k = 0; k < tv[i].lat; k++)
                sq.push_back({1'b1, 1'b0, exp_strb(tv[i].ir[31:27], k)});
            for (int k = 0; k < tv[i].lat; k++)
                sb_check($sformatf("seq_%s_t%0d", tv[i].nm, k));
            @(posedge clk);
            #1;
            case (tv[i].kind)
                0: chk($sformatf("res_%s", tv[i].nm), rf[tv[i].idx], tv[i].val);
                1: chk($sformatf("res_%s", tv[i].nm), mem[tv[i].idx], tv[i].val);
                default: chk("halt_state", {1'b0, obs()}, {1'b0, 1'b0, 1'b1, 29'd0});
            endcase
            chk($sformatf("pc_%s", tv[i].nm), pc, 32'(i + 1));
        end

        // Halted: start ignored, no further fetch, PC holds
        bus.start = 1'b1;
        repeat (3) @(posedge clk);
        #1 bus.start = 1'b0;
        @(negedge clk);
        chk("halt_ignores_start", {1'b0, obs()}, {1'b0, 1'b0, 1'b1, 29'd0});
        chk("halt_pc_hold", pc, 32'd16);

        // sub with a 3-cycle stall in T4, then st aborted by reset in T7
        clear   = 1'b0;
        pc_init = 32'h20;
        poke(8'h20, enc_r(5'b00100, 4'd14, 4'd3, 4'd1));
        poke(8'h21, enc_m(5'b00010, 4'd1, 4'd0, 19'h5C));
        chk("halt_cleared", {1'b0, obs()}, 32'h0);
        @(posedge clk);
        #1 clear = 1'b1;
        do_start();
        for (int j = 0; j < 9; j++) begin
            if (j < 4)       sq.push_back({1'b1, 1'b0, exp_strb(5'b00100, j)});
            else if (j < 7)  sq.push_back({1'b1, 1'b0, 29'd0});
            else             sq.push_back({1'b1, 1'b0, exp_strb(5'b00100, j - 3)});
        end
        for (int j = 0; j < 9; j++) begin
            if (j > 0) begin
                @(posedge clk);
                #1;
            end
            bus.stall = (j >= 4 && j <= 6);
            sb_check($sformatf("stall_sub_c%0d", j));
        end
        @(posedge clk);
        #1 chk("res_stalled_sub", rf[14], 32'd7);
        for (int k = 0; k < 8; k++) sq.push_back({1'b1, 1'b0, exp_strb(5'b00010, k)});
        for (int k = 0; k < 8; k++) sb_check($sformatf("seq_st2_t%0d", k));
        chk("st2_write_in_t7", {31'd0, bus.Write}, 32'd1);
        #2 clear = 1'b0;
        #1 chk("abort_write", {31'd0, bus.Write}, 32'd0);
        chk("abort_outputs", {1'b0, obs()}, 32'h0);
        @(posedge clk);
        #1 chk("abort_no_mem_write", mem[8'h5C], 32'h0);

        // Illegal opcode 11111 halts after T3
        pc_init = 32'h30;
        poke(8'h30, 32'hF800_0000);
        @(posedge clk);
        #1 clear = 1'b1;
        do_start();
        for (int k = 0; k < 4; k++) sq.push_back({1'b1, 1'b0, exp_strb(5'b11111, k)});
        for (int k = 0; k < 4; k++) sb_check($sformatf("seq_illegal_t%0d", k));
        @(negedge clk);
        chk("illegal_halted", {1'b0, obs()}, {1'b0, 1'b0, 1'b1, 29'd0});
        repeat (2) @(negedge clk);
        chk("illegal_pc_hold", pc, 32'h31);
        chk("scoreboard_drained", 32'(sq.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/control_sequencer.md
# control_sequencer

Hardwired control unit that drives the single-bus datapath through instruction fetch and execute. It replaces hand-written strobe sequences with a Moore state machine. The FSM decodes the opcode held in IR and steps through T-states, asserting the datapath's register-enable, bus-select, ALU-op and memory strobes. It sits beside the datapath, consuming IR and producing every control input except clock and reset.

## Interface
- `OPC_W`, 5, opcode width (IR[31:27])
- `clk`  in  1  system clock; all state changes on rising edge
- `clear`  in  1  asynchronous, active-low reset (`clear`=0 resets)
- `start`  in  1  leave IDLE and begin fetching at current PC
- `stall`  in  1  freeze FSM in current state; all strobes forced 0 while high
- `IR`  in  32  instruction register contents from datapath
- `PCout, Zlowout, MDRout, Cout, BAout, Rout`  out  1 each  bus drivers
- `MARin, Zin, PCin, MDRin, IRin, Yin, Rin, IncPC`  out  1 each  register enables
- `Gra, Grb, Grc`  out  1 each  register-field selects
- `Read, Write`  out  1 each  memory strobes
- `ADD, SUB, AND, OR, SHR, SHL, ROR, ROL, NEG, NOT`  out  1 each  ALU op selects (at most one high)
- `run`  out  1  high in any state except IDLE and HALT
- `halted`  out  1  high in HALT

## Operation
- Supported opcodes: ld 00000, ldi 00001, st 00010, add 00011, sub 00100, and 00101, or 00110, shr 00111, shl 01000, ror 01001, rol 01010, neg 01110, not 01111, halt 11011. Every other opcode is illegal and goes to HALT.
- States: IDLE, T0..T7, HALT. Outputs are decoded from the state register plus IR[31:27]; no output depends on `start`. The only other input that affects outputs is `stall`, which gates all strobes to 0.
- Fetch, common to all instructions:
  - T0: PCout MARin IncPC Zin
  - T1: Zlowout PCin Read MDRin
  - T2: MDRout IRin
- ld:
  - T3: Grb BAout Yin
  - T4: Cout ADD Zin
  - T5: Zlowout MARin
  - T6: Read MDRin
  - T7: MDRout Gra Rin
- ldi: T3 and T4 as ld; T5: Zlowout Gra Rin.
- st: T3–T5 as ld; T6: Gra Rout MDRin; T7: Write.
- add/sub/and/or/shr/shl/ror/rol:
  - T3: Grb Rout Yin
  - T4: Grc Rout <op> Zin
  - T5: Zlowout Gra Rin
- neg/not:
  - T3: Grb Rout <op> Zin
  - T4: Zlowout Gra Rin
- halt/illegal: T3 goes to HALT. HALT asserts no strobes and is left only by reset.
- After the last T-state of an instruction, the next state is T0 (back-to-back fetch). `start` is not re-sampled.

## Timing
- Reset: async on `clear` falling. State is IDLE; every strobe, `run` and `halted` are 0 while `clear`=0 and in IDLE.
- IDLE→T0 on the first rising edge with `start`=1 and `stall`=0.
- Each T-state lasts exactly one cycle unless `stall`=1. While stalled, the state holds and outputs are 0. Release resumes the same T-state with its full strobe set.
- Memory is synchronous with one-cycle access. Read+MDRin in a single cycle captures data at the end of that cycle.
- IR is valid from T3 onward because the datapath loads it at the T2→T3 edge. Opcode decode uses the live IR in T3..T7.
- Latency in cycles, start-of-T0 to start of next T0:
  - ld 8
  - st 8
  - ldi 6
  - ALU reg-reg 6
  - neg/not 5
  - halt reaches HALT after 4 cycles
- `clear` asserted mid-instruction aborts immediately to IDLE. No partial Write continues past reset.
- `start` asserted while running or halted is ignored.

## Test plan
- Reset mid-st: assert `clear`=0 during T7 → Write drops to 0 asynchronously, state IDLE, `run`=0.
- ld R1,0x5A(R0), mem[0x5A]=0x55 → R1=0x00000055 after 8 cycles; PC=1; Read high in T1 and T6 only.
- st R1,0x5A(R0) with R1=0x55 → mem[0x5A]=0x55. Write is high for exactly 1 cycle, in T7.
- add R3,R1,R2 then neg R4,R3 with R1=5, R2=7 → R3=12, R4=0xFFFFFFF4; the add starts at cycle 0 and the neg's T0 starts at cycle 6.
- `stall`=1 for 3 cycles during T4 of sub → all strobes 0 while stalled; the sub result is correct; total latency is 6+3 cycles.
- Opcode 11111 (illegal) and opcode 11011 (halt) → `halted`=1 at cycle 4. No further fetch occurs, and PC holds at its post-fetch value.
